regfile_sb: RTL

- Parametrised successor to the single-write, two-read integer register file, for the pipelined RV32 core.
- Adds configurable width, depth and read-port count, posedge writes, and a per-register busy scoreboard with a valid/ready issue handshake.
- Adds an outstanding-write counter and optional same-cycle writeback-to-read bypass.
- Sits between decode/issue (reads, busy checks, destination reservation) and writeback.

---
 rtl/regfile_sb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a per-register busy
// scoreboard, valid/ready destination reservation and an outstanding-write
// counter, sitting between decode/issue and writeback of the RV32 pipeline.
//
// Register 0 is hardwired to zero and can never be marked busy.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a read port addressing the register being written back this
//               cycle sees wb_data and rd_busy 0 in the same cycle.
//   undefined - reads always return the stored (pre-edge) value and busy bit.
//
// Reset is asynchronous and active-low on rst.

module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NRD    = 2,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*WIDTH-1:0]    rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_dest,
  output logic                    issue_ready,
  input  logic                    wb_valid,
  input  logic [ADDR_W-1:0]       wb_dest,
  input  logic [WIDTH-1:0]        wb_data,
  output logic [CNT_W-1:0]        pending_cnt
);

  // Architectural state: register contents, busy scoreboard, busy count.
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  // Decoded handshake events for the current cycle.
  logic issue_fire;
  logic wb_fire;
  logic cnt_inc;
  logic cnt_dec;

  // A reservation is possible for x0 (a no-op) or for any idle register.
  assign issue_ready = (issue_dest == '0) || !busy[issue_dest];

  // Issues to x0 are accepted but must not touch the scoreboard, so they are
  // filtered out of the fire signal; writebacks to x0 are ignored entirely.
  assign issue_fire = issue_valid && issue_ready && (issue_dest != '0);
  assign wb_fire    = wb_valid && (wb_dest != '0);

  // An accepted issue always targets an idle register, so it always adds one.
  // A writeback removes one only if it clears a set bit and no same-cycle
  // issue re-reserves that register (the new producer wins).
  assign cnt_inc = issue_fire;
  assign cnt_dec = wb_fire && busy[wb_dest] &&
                   !(issue_fire && (issue_dest == wb_dest));

  // Register array: writeback data lands on the edge; x0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else if (wb_fire) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // Scoreboard: writeback clears first, then an issue sets, so a same-cycle
  // issue and writeback to one register leaves it busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (wb_fire) begin
        busy[wb_dest] <= 1'b0;
      end
      if (issue_fire) begin
        busy[issue_dest] <= 1'b1;
      end
    end
  end

  // Outstanding-write counter, tracked incrementally alongside the scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_cnt <= '0;
    end else begin
      pending_cnt <= pending_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  // One combinational read path per port.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;
    logic [WIDTH-1:0]  port_data;
    logic              port_busy;

    assign port_addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Select stored data and busy, with x0 forced to zero and, when enabled,
    // the in-flight writeback forwarded ahead of the register array.
    always_comb begin
      port_data = regs[port_addr];
      port_busy = busy[port_addr];
`ifdef REGFILE_BYPASS_EN
      if (wb_fire && (wb_dest == port_addr)) begin
        port_data = wb_data;
        port_busy = 1'b0;
      end
`endif
      if (port_addr == '0) begin
        port_data = '0;
        port_busy = 1'b0;
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = port_data;
    assign rd_busy[p]                = port_busy;
  end

`ifndef SYNTHESIS
  // The counter must always match the number of busy registers.
  property p_cnt_matches_busy;
    @(posedge clk) disable iff (!rst)
      pending_cnt == CNT_W'($countones(busy));
  endproperty
  a_cnt_matches_busy: assert property (p_cnt_matches_busy)
    else $error("regfile_sb: pending_cnt out of step with busy bits");

  // x0 can never be reserved, which also bounds the counter at DEPTH-1.
  property p_x0_never_busy;
    @(posedge clk) disable iff (!rst)
      !busy[0] && (pending_cnt <= CNT_W'(DEPTH - 1));
  endproperty
  a_x0_never_busy: assert property (p_x0_never_busy)
    else $error("regfile_sb: x0 busy or counter above DEPTH-1");
`endif

endmodule
